// File: rtl/ddr_pkg.sv
// Shared types and constants for the rhythm-game judgment path.
package ddr_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_JUDGE,
    S_HOLD,
    S_DONE
  } state_t;

  localparam int ARROW_W   = 4;
  localparam int SCORE_MAX = 9999;
  localparam int END_BIT   = 4;
  localparam int COMBO_MAX = 255;

endpackage

// File: rtl/score_keeper.sv
// Score, combo and max-combo bookkeeping; updates one cycle after a hit/miss request.
// Saturates score at SCORE_MAX and combo at COMBO_MAX; clear has priority over hit/miss.
module score_keeper
  import ddr_pkg::*;
#(
  parameter int HIT_PTS  = 10,
  parameter int BONUS_AT = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hit,
  input  logic        miss,
  input  logic        clear,
  output logic [13:0] score,
  output logic [7:0]  combo,
  output logic [7:0]  max_combo
);

  int          pts;
  int          sum;
  logic [13:0] score_nxt;
  logic [7:0]  combo_nxt;

  always_comb begin
    pts       = (int'(combo) >= BONUS_AT) ? 2 * HIT_PTS : HIT_PTS;
    sum       = int'(score) + pts;
    score_nxt = (sum > SCORE_MAX) ? 14'(SCORE_MAX) : 14'(sum);
    combo_nxt = (int'(combo) >= COMBO_MAX) ? combo : combo + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      score     <= '0;
      combo     <= '0;
      max_combo <= '0;
    end else if (hit) begin
      score     <= score_nxt;
      combo     <= combo_nxt;
      max_combo <= (combo_nxt > max_combo) ? combo_nxt : max_combo;
    end else if (miss) begin
      combo     <= '0;
    end
  end

endmodule

// File: rtl/judge_sequencer.sv
// Steps the pattern ROM, opens one judgment window per step and turns correct_input into hit/miss.
// Each non-end step lasts WINDOW ticks plus two cycles of FETCH/LOAD overhead.
module judge_sequencer
  import ddr_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int WINDOW   = 4,
  parameter int HIT_PTS  = 10,
  parameter int BONUS_AT = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              tick,
  input  logic              correct_input,
  input  logic [4:0]        rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [3:0]        next,
  output logic              window_open,
  output logic              hit_pulse,
  output logic              miss_pulse,
  output logic [13:0]       score,
  output logic [7:0]        combo,
  output logic [7:0]        max_combo,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (WINDOW < 2) ? 1 : $clog2(WINDOW + 1);

  state_t             state, state_nxt;
  logic [ARROW_W-1:0] arrows_q;
  logic [CNT_W-1:0]   cnt;
  logic               tick_last;
  logic               hit, miss, advance, clear, load_step;

  assign tick_last = tick && (cnt == CNT_W'(WINDOW - 1));

  always_comb begin
    state_nxt = state;
    hit       = 1'b0;
    miss      = 1'b0;
    advance   = 1'b0;
    clear     = 1'b0;
    load_step = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_LOAD;
      S_LOAD: begin
        load_step = 1'b1;
        if (rom_data[END_BIT])                state_nxt = S_DONE;
        else if (rom_data[ARROW_W-1:0] == '0) state_nxt = S_HOLD;
        else                                  state_nxt = S_JUDGE;
      end
      S_JUDGE: begin
        // A hit on the closing tick still ends the step, so no extra HOLD pass.
        if (correct_input) begin
          hit = 1'b1;
          if (tick_last) advance = 1'b1;
          else           state_nxt = S_HOLD;
        end else if (tick_last) begin
          miss    = 1'b1;
          advance = 1'b1;
        end
      end
      S_HOLD: begin
        if (tick_last) advance = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (advance) state_nxt = (&rom_addr) ? S_DONE : S_FETCH;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rom_addr   <= '0;
      arrows_q   <= '0;
      cnt        <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      hit_pulse  <= hit;
      miss_pulse <= miss;
      if (clear) rom_addr <= '0;
      else if (advance && !(&rom_addr)) rom_addr <= rom_addr + 1'b1;
      if (load_step) begin
        arrows_q <= rom_data[ARROW_W-1:0];
        cnt      <= '0;
      end else if (tick && (state == S_JUDGE || state == S_HOLD)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign next        = (state == S_JUDGE) ? arrows_q : '0;
  assign window_open = (state == S_JUDGE);
  assign busy        = (state == S_FETCH) || (state == S_LOAD) ||
                       (state == S_JUDGE) || (state == S_HOLD);
  assign done        = (state == S_DONE);

  score_keeper #(
    .HIT_PTS (HIT_PTS),
    .BONUS_AT(BONUS_AT)
  ) u_score (
    .clk      (clk),
    .rst_n    (rst_n),
    .hit      (hit),
    .miss     (miss),
    .clear    (clear),
    .score    (score),
    .combo    (combo),
    .max_combo(max_combo)
  );

endmodule

// File: tb/tb_judge_sequencer.sv
// Directed bench for judge_sequencer; a second instance with large HIT_PTS exercises score saturation.
module tb_judge_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, tick, correct_input;
  logic [4:0]  rom_data;
  logic [7:0]  rom_addr;
  logic [3:0]  next;
  logic        window_open, hit_pulse, miss_pulse, busy, done;
  logic [13:0] score;
  logic [7:0]  combo, max_combo;

  logic [7:0]  rom_addr2;
  logic [3:0]  next2;
  logic        window_open2, hit_pulse2, miss_pulse2, busy2, done2;
  logic [13:0] score2;
  logic [7:0]  combo2, max_combo2;

  logic [4:0]  rom [256];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          hits     = 0;
  int          misses   = 0;
  int          h0, m0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  always @(posedge clk) begin
    if (hit_pulse)  hits   <= hits + 1;
    if (miss_pulse) misses <= misses + 1;
  end

  judge_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tick(tick),
    .correct_input(correct_input), .rom_data(rom_data), .rom_addr(rom_addr),
    .next(next), .window_open(window_open), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .score(score), .combo(combo),
    .max_combo(max_combo), .busy(busy), .done(done)
  );

  judge_sequencer #(.HIT_PTS(4000)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .tick(tick),
    .correct_input(correct_input), .rom_data(rom_data), .rom_addr(rom_addr2),
    .next(next2), .window_open(window_open2), .hit_pulse(hit_pulse2),
    .miss_pulse(miss_pulse2), .score(score2), .combo(combo2),
    .max_combo(max_combo2), .busy(busy2), .done(done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1; step(); tick = 1'b0; step();
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_hit();
    correct_input = 1'b1; step(); correct_input = 1'b0;
  endtask

  task automatic wait_open(input string tag);
    int n = 0;
    while (!window_open && n < 40) begin step(); n++; end
    check(tag, window_open, 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 400) begin
      if (n % 2 == 0) tick = 1'b1;
      step(); tick = 1'b0; n++;
    end
    check(tag, done, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 5'h10;
    rst_n = 1'b0; start = 1'b0; tick = 1'b0; correct_input = 1'b0;
    repeat (3) step();

    // reset state
    check("rst_score", score, 0);
    check("rst_combo", combo, 0);
    check("rst_max", max_combo, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_window", window_open, 0);
    check("rst_next", next, 0);
    rst_n = 1'b1;
    step();

    // two hits then end marker
    rom[0] = 5'b00001; rom[1] = 5'b00010; rom[2] = 5'b10000;
    h0 = hits; m0 = misses;
    pulse_start();
    check("t1_fetch_busy", busy, 1);
    step();
    step();
    check("t1_judge_t3", window_open, 1);
    check("t1_next0", next, 4'b0001);
    do_tick(); do_tick();
    pulse_hit();
    check("t1_hit_pulse", hit_pulse, 1);
    check("t1_score1", score, 10);
    check("t1_window_fell", window_open, 0);
    do_tick(); do_tick();
    wait_open("t1_open2");
    check("t1_next1", next, 4'b0010);
    do_tick();
    pulse_hit();
    do_tick(); do_tick(); do_tick();
    wait_done("t1_done");
    check("t1_score", score, 20);
    check("t1_combo", combo, 2);
    check("t1_max", max_combo, 2);
    check("t1_hits", hits - h0, 2);
    check("t1_misses", misses - m0, 0);
    check("t1_addr", rom_addr, 2);
    check("t1_busy", busy, 0);

    // hit then a miss
    rom[0] = 5'b00001; rom[1] = 5'b00100; rom[2] = 5'b10000;
    pulse_start();
    wait_open("t2_open1");
    pulse_hit();
    repeat (4) do_tick();
    wait_open("t2_open2");
    do_tick(); do_tick(); do_tick();
    check("t2_no_early_miss", miss_pulse, 0);
    check("t2_still_open", window_open, 1);
    tick = 1'b1; step(); tick = 1'b0;
    check("t2_miss_pulse", miss_pulse, 1);
    check("t2_combo0", combo, 0);
    check("t2_score", score, 10);
    check("t2_max", max_combo, 1);
    check("t2_closed", window_open, 0);
    check("t2_addr", rom_addr, 2);
    wait_done("t2_done");

    // twelve hits with bonus after combo 10
    for (int i = 0; i < 12; i++) rom[i] = 5'b00001;
    rom[12] = 5'b10000;
    h0 = hits;
    pulse_start();
    correct_input = 1'b1;
    wait_done("t3_done");
    correct_input = 1'b0;
    check("t3_score", score, 140);
    check("t3_combo", combo, 12);
    check("t3_max", max_combo, 12);
    check("t3_hits", hits - h0, 12);
    check("t6_saturate", score2, 9999);

    // rest step
    rom[0] = 5'b00000; rom[1] = 5'b01000; rom[2] = 5'b10000;
    h0 = hits; m0 = misses;
    pulse_start();
    step(); step();
    check("t4_hold_busy", busy, 1);
    check("t4_window", window_open, 0);
    check("t4_next", next, 0);
    do_tick(); do_tick(); do_tick();
    check("t4_addr_held", rom_addr, 0);
    tick = 1'b1; step(); tick = 1'b0;
    check("t4_addr_adv", rom_addr, 1);
    check("t4_no_pulses", (hits - h0) + (misses - m0), 0);
    wait_open("t4_open");
    check("t4_next1", next, 4'b1000);
    pulse_hit();
    wait_done("t4_done");

    // hit on closing tick, start mid-song ignored
    rom[0] = 5'b01000; rom[1] = 5'b10000;
    h0 = hits; m0 = misses;
    pulse_start();
    wait_open("t5_open");
    do_tick(); do_tick(); do_tick();
    pulse_start();
    check("t5_start_ignored", window_open, 1);
    check("t5_addr", rom_addr, 0);
    tick = 1'b1; correct_input = 1'b1; step(); tick = 1'b0; correct_input = 1'b0;
    check("t5_hit", hit_pulse, 1);
    check("t5_no_miss", miss_pulse, 0);
    check("t5_advanced", rom_addr, 1);
    wait_done("t5_done");
    check("t5_score", score, 10);
    check("t5_misses", misses - m0, 0);

    // reset mid-song
    rom[0] = 5'b00001; rom[1] = 5'b00010; rom[2] = 5'b10000;
    pulse_start();
    wait_open("t6_open1");
    pulse_hit();
    repeat (4) do_tick();
    wait_open("t6_open2");
    h0 = hits; m0 = misses;
    rst_n = 1'b0; step();
    check("t6_rst_window", window_open, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_score", score, 0);
    check("t6_rst_combo", combo, 0);
    check("t6_rst_max", max_combo, 0);
    check("t6_rst_addr", rom_addr, 0);
    check("t6_rst_next", next, 0);
    rst_n = 1'b1; step(); step();
    check("t6_idle_done", done, 0);
    check("t6_idle_busy", busy, 0);
    check("t6_no_pulses", (hits - h0) + (misses - m0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
